// File: rtl/tk1_spi_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tk1_spi_seq_pkg
//  Purpose  : Shared constants, register map and FSM encoding for the tk1
//             SPI read sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package tk1_spi_seq_pkg;

   // API word addresses
   localparam logic [7:0] ADDR_CTRL   = 8'h00;
   localparam logic [7:0] ADDR_STATUS = 8'h01;
   localparam logic [7:0] ADDR_FLASH  = 8'h02;
   localparam logic [7:0] ADDR_LEN    = 8'h03;
   localparam logic [7:0] ADDR_RDATA  = 8'h04;
   localparam logic [7:0] ADDR_LEVEL  = 8'h05;

   // CTRL bit positions
   localparam int CTRL_START = 0;
   localparam int CTRL_ABORT = 1;

   // STATUS bit positions
   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_EMPTY   = 2;
   localparam int STAT_FULL    = 3;
   localparam int STAT_ABORTED = 4;
   localparam int STAT_W       = 5;

   // Flash READ opcode
   localparam logic [7:0] READ_OPCODE = 8'h03;

   // Sequencer states
   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_EN_ON   = 4'd1,
      S_LOAD    = 4'd2,
      S_KICK    = 4'd3,
      S_WAIT_LO = 4'd4,
      S_WAIT_HI = 4'd5,
      S_CAPT    = 4'd6,
      S_EN_OFF  = 4'd7,
      S_FIN     = 4'd8
   } state_t;

   // Command byte idx of the READ header: opcode then address MSB first
   function automatic logic [7:0] cmd_byte(input logic [1:0] idx, input logic [23:0] addr);
      logic [7:0] b;
      case (idx)
         2'd0:    b = READ_OPCODE;
         2'd1:    b = addr[23:16];
         2'd2:    b = addr[15:8];
         default: b = addr[7:0];
      endcase
      return b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tk1_spi_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : tk1_spi_seq_if
//  Purpose  : CPU MMIO bus plus SPI master byte-interface control signals.
//             slave  = the sequencer's view, master = the environment's view.
//  Revision : 1.0 - initial release
// ============================================================================
interface tk1_spi_seq_if;
   logic        cs;
   logic        we;
   logic [7:0]  address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;
   logic        spi_enable;
   logic        spi_enable_vld;
   logic [7:0]  spi_tx_data;
   logic        spi_tx_data_vld;
   logic        spi_start;
   logic        spi_ready;
   logic [7:0]  spi_rx_data;

   modport slave (
      input  cs, we, address, write_data, spi_ready, spi_rx_data,
      output read_data, ready, spi_enable, spi_enable_vld,
             spi_tx_data, spi_tx_data_vld, spi_start
   );

   modport master (
      output cs, we, address, write_data, spi_ready, spi_rx_data,
      input  read_data, ready, spi_enable, spi_enable_vld,
             spi_tx_data, spi_tx_data_vld, spi_start
   );
endinterface
`default_nettype wire

// File: rtl/tk1_spi_seq_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tk1_spi_seq_fifo
//  Purpose  : Synchronous receive FIFO. Push when full and pop when empty
//             are ignored; simultaneous push/pop keeps the level.
//  Revision : 1.0 - initial release
// ============================================================================
module tk1_spi_seq_fifo #(
   parameter  int DEPTH = 16,
   parameter  int WIDTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  wire logic             clk,
   input  wire logic             reset_n,
   input  wire logic             push_i,
   input  wire logic [WIDTH-1:0] din_i,
   input  wire logic             pop_i,
   output logic      [WIDTH-1:0] head_o,
   output logic      [LW-1:0]    level_o,
   output logic                  empty_o,
   output logic                  full_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [LW-1:0]    level_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (level_q == '0);
   assign full_o  = (level_q == LW'(DEPTH));
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign head_o  = mem_q[rd_ptr_q];
   assign level_o = level_q;

   // Storage write; contents need no reset because level gates visibility
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

   // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: rtl/tk1_spi_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tk1_spi_seq
//  Purpose  : Hardware flash READ sequencer driving the tk1 SPI master byte
//             interface; received data is buffered for CPU pops over MMIO.
//  Revision : 1.0 - initial release
// ============================================================================
module tk1_spi_seq
   import tk1_spi_seq_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int LEN_WIDTH  = 16
) (
   input wire logic     clk,
   input wire logic     reset_n,
   tk1_spi_seq_if.slave bus
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   state_t               state_q, state_d;
   logic [23:0]          flash_addr_q, flash_addr_d;
   logic [23:0]          addr_cp_q, addr_cp_d;
   logic [LEN_WIDTH-1:0] len_q, len_d;
   logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
   logic [1:0]           idx_q, idx_d;
   logic                 data_ph_q, data_ph_d;   // 0: command header, 1: data
   logic                 capt_q, capt_d;         // CAPT already consumed the byte
   logic                 tmo_q, tmo_d;           // WAIT_LO second cycle
   logic                 done_q, done_d;
   logic                 aborted_q, aborted_d;
   logic                 abort_req_q, abort_req_d;

   logic                 push, en, en_vld, tx_vld, start;
   logic [7:0]           tx_data;
   logic [7:0]           fifo_head;
   logic [LVL_W-1:0]     fifo_level;
   logic                 fifo_empty, fifo_full, pop;
   logic [STAT_W-1:0]    status;
   logic [31:0]          rdata;
   logic                 wr, rd, ctrl_start, ctrl_abort;
   logic                 unused_wdata;

   assign wr         = bus.cs && bus.we;
   assign rd         = bus.cs && !bus.we;
   // Abort wins over a simultaneous start
   assign ctrl_abort = wr && (bus.address == ADDR_CTRL) && bus.write_data[CTRL_ABORT];
   assign ctrl_start = wr && (bus.address == ADDR_CTRL) && bus.write_data[CTRL_START]
                       && !bus.write_data[CTRL_ABORT];
   assign pop        = rd && (bus.address == ADDR_RDATA);
   assign unused_wdata = ^bus.write_data;

   tk1_spi_seq_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (push),
      .din_i   (bus.spi_rx_data),
      .pop_i   (pop),
      .head_o  (fifo_head),
      .level_o (fifo_level),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   // State and control registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         flash_addr_q <= '0;
         addr_cp_q    <= '0;
         len_q        <= '0;
         cnt_q        <= '0;
         idx_q        <= '0;
         data_ph_q    <= 1'b0;
         capt_q       <= 1'b0;
         tmo_q        <= 1'b0;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
         abort_req_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         flash_addr_q <= flash_addr_d;
         addr_cp_q    <= addr_cp_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         data_ph_q    <= data_ph_d;
         capt_q       <= capt_d;
         tmo_q        <= tmo_d;
         done_q       <= done_d;
         aborted_q    <= aborted_d;
         abort_req_q  <= abort_req_d;
      end
   end

   // Next-state, register updates and SPI strobes of the read sequence
   always_comb begin
      state_d      = state_q;
      flash_addr_d = flash_addr_q;
      addr_cp_d    = addr_cp_q;
      len_d        = len_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      data_ph_d    = data_ph_q;
      capt_d       = capt_q;
      tmo_d        = tmo_q;
      done_d       = done_q;
      aborted_d    = aborted_q;
      abort_req_d  = abort_req_q;
      push         = 1'b0;
      en           = 1'b0;
      en_vld       = 1'b0;
      tx_data      = 8'h00;
      tx_vld       = 1'b0;
      start        = 1'b0;

      if (ctrl_abort) begin
         aborted_d = 1'b1;
         if (state_q != S_IDLE) abort_req_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (wr && bus.address == ADDR_FLASH) flash_addr_d = bus.write_data[23:0];
            if (wr && bus.address == ADDR_LEN)   len_d = bus.write_data[LEN_WIDTH-1:0];
            if (ctrl_start) begin
               aborted_d   = 1'b0;
               abort_req_d = 1'b0;
               cnt_d       = len_q;
               addr_cp_d   = flash_addr_q;
               idx_d       = 2'd0;
               data_ph_d   = 1'b0;
               done_d      = (len_q == '0);
               if (len_q != '0) state_d = S_EN_ON;
            end
         end
         S_EN_ON: begin
            en      = 1'b1;
            en_vld  = 1'b1;
            state_d = S_LOAD;
         end
         S_LOAD: begin
            en      = 1'b1;
            tx_vld  = 1'b1;
            tx_data = data_ph_q ? 8'h00 : cmd_byte(idx_q, addr_cp_q);
            state_d = S_KICK;
         end
         S_KICK: begin
            en      = 1'b1;
            start   = 1'b1;
            tmo_d   = 1'b0;
            state_d = S_WAIT_LO;
         end
         S_WAIT_LO: begin
            en = 1'b1;
            if (!bus.spi_ready || tmo_q) state_d = S_WAIT_HI;
            else                         tmo_d   = 1'b1;
         end
         S_WAIT_HI: begin
            en = 1'b1;
            if (bus.spi_ready) begin
               capt_d  = 1'b0;
               state_d = S_CAPT;
            end
         end
         S_CAPT: begin
            en = 1'b1;
            // First cycle consumes the byte; later cycles decide where to go,
            // holding here while a full FIFO has no room for the next byte.
            if (!capt_q) begin
               capt_d = 1'b1;
               if (data_ph_q) begin
                  push  = 1'b1;
                  cnt_d = cnt_q - LEN_WIDTH'(1);
               end else if (idx_q == 2'd3) begin
                  data_ph_d = 1'b1;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end else if (abort_req_q || cnt_q == '0) begin
               state_d = S_EN_OFF;
            end else if (!fifo_full) begin
               state_d = S_LOAD;
            end
         end
         S_EN_OFF: begin
            en_vld  = 1'b1;
            state_d = S_FIN;
         end
         S_FIN: begin
            done_d      = 1'b1;
            abort_req_d = 1'b0;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // STATUS word and combinational API read mux
   always_comb begin
      status               = '0;
      status[STAT_BUSY]    = (state_q != S_IDLE);
      status[STAT_DONE]    = done_q;
      status[STAT_EMPTY]   = fifo_empty;
      status[STAT_FULL]    = fifo_full;
      status[STAT_ABORTED] = aborted_q;
      rdata = 32'd0;
      if (bus.cs) begin
         case (bus.address)
            ADDR_STATUS: rdata = 32'(status);
            ADDR_FLASH:  rdata = {8'd0, flash_addr_q};
            ADDR_LEN:    rdata = 32'(len_q);
            ADDR_RDATA:  rdata = {24'd0, (fifo_empty ? 8'h00 : fifo_head)};
            ADDR_LEVEL:  rdata = 32'(fifo_level);
            default:     rdata = 32'd0;
         endcase
      end
   end

   assign bus.read_data       = rdata;
   assign bus.ready           = bus.cs;
   assign bus.spi_enable      = en;
   assign bus.spi_enable_vld  = en_vld;
   assign bus.spi_tx_data     = tx_data;
   assign bus.spi_tx_data_vld = tx_vld;
   assign bus.spi_start       = start;
endmodule
`default_nettype wire

// File: tb/tb_tk1_spi_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tk1_spi_seq
//  Purpose  : Directed plus randomised bench for tk1_spi_seq with a flash /
//             SPI master model and an expected-byte-stream reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tk1_spi_seq;
   import tk1_spi_seq_pkg::*;

   localparam int DEPTH  = 16;
   localparam int EV_ON  = 256;
   localparam int EV_OFF = 257;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   tk1_spi_seq_if bus();

   tk1_spi_seq #(.FIFO_DEPTH(DEPTH), .LEN_WIDTH(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int         n_asserts = 0;
   int         n_fail    = 0;
   int         ev_q[$];
   int         starts    = 0;
   logic [7:0] seed      = 8'h00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Bus monitor: logs enable strobes and transmitted bytes in order
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (bus.spi_enable_vld)  ev_q.push_back(bus.spi_enable ? EV_ON : EV_OFF);
         if (bus.spi_tx_data_vld) ev_q.push_back(int'(bus.spi_tx_data));
         if (bus.spi_start)       starts++;
      end
   end

   // SPI master + flash model: header bytes return junk, data byte k returns seed+k
   initial begin : flash_model
      int n;
      n = 0;
      bus.spi_ready   = 1'b1;
      bus.spi_rx_data = 8'h00;
      forever begin
         @(negedge clk);
         if (bus.spi_enable_vld && bus.spi_enable) n = 0;
         if (bus.spi_start) begin
            @(posedge clk);
            #1 bus.spi_ready = 1'b0;
            repeat ($urandom_range(4, 1)) @(posedge clk);
            #1;
            bus.spi_rx_data = (n < 4) ? 8'($urandom) : 8'(seed + 8'(n - 4));
            bus.spi_ready   = 1'b1;
            n++;
         end
      end
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      bus.cs = 1'b1; bus.we = 1'b1; bus.address = a; bus.write_data = d;
      @(posedge clk); #1;
      bus.cs = 1'b0; bus.we = 1'b0; bus.write_data = 32'd0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] d);
      @(posedge clk); #1;
      bus.cs = 1'b1; bus.we = 1'b0; bus.address = a;
      #1 d = bus.read_data;
      @(posedge clk); #1;
      bus.cs = 1'b0;
   endtask

   task automatic rd_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
      logic [31:0] d;
      rd(a, d);
      check(tag, d, exp);
   endtask

   task automatic wait_idle(input string tag);
      logic [31:0] s;
      int i;
      s = 32'd1;
      for (i = 0; i < 2000 && s[STAT_BUSY]; i++) rd(ADDR_STATUS, s);
      check({tag, " finish"}, 32'(!s[STAT_BUSY]), 32'd1);
   endtask

   task automatic wait_starts(input int n, input string tag);
      for (int i = 0; i < 4000 && starts < n; i++) begin
         @(negedge clk); #1;
      end
      check({tag, " starts"}, 32'(starts >= n), 32'd1);
   endtask

   // Reference: enable-on, READ header, nd dummy bytes, enable-off
   task automatic check_events(input string tag, input logic [23:0] a, input int nd);
      int exp[$];
      exp.push_back(EV_ON);
      exp.push_back(int'(READ_OPCODE));
      exp.push_back(int'(a[23:16]));
      exp.push_back(int'(a[15:8]));
      exp.push_back(int'(a[7:0]));
      for (int i = 0; i < nd; i++) exp.push_back(0);
      exp.push_back(EV_OFF);
      check({tag, " nevents"}, ev_q.size(), exp.size());
      for (int i = 0; i < exp.size() && i < ev_q.size(); i++)
         check($sformatf("%s ev%0d", tag, i), ev_q[i], exp[i]);
   endtask

   task automatic pop_expect(input string tag, input logic [7:0] base, input int cnt);
      for (int k = 0; k < cnt; k++)
         rd_check($sformatf("%s pop%0d", tag, k), ADDR_RDATA, {24'd0, 8'(base + 8'(k))});
   endtask

   task automatic begin_xfer(input logic [23:0] a, input int len);
      wr(ADDR_FLASH, {8'd0, a});
      wr(ADDR_LEN, len);
      ev_q.delete();
      starts = 0;
      wr(ADDR_CTRL, 32'h1);
   endtask

   initial begin : stimulus
      logic [23:0] a;
      int          len;
      int          s0;
      logic [31:0] d;
      int          i;

      bus.cs = 1'b0; bus.we = 1'b0; bus.address = 8'h00; bus.write_data = 32'd0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst read_data cs0", bus.read_data, 32'd0);
      check("rst ready cs0", 32'(bus.ready), 32'd0);
      check("rst strobes", {20'd0, bus.spi_enable, bus.spi_enable_vld, bus.spi_tx_data_vld,
                            bus.spi_start, bus.spi_tx_data}, 32'd0);
      reset_n = 1'b1;
      rd_check("rst status", ADDR_STATUS, 32'h04);
      rd_check("rst level", ADDR_LEVEL, 32'd0);
      rd_check("rst flash_addr", ADDR_FLASH, 32'd0);
      rd_check("rst len", ADDR_LEN, 32'd0);
      @(posedge clk); #1 bus.cs = 1'b1; bus.address = ADDR_CTRL;
      #1 check("ready follows cs", 32'(bus.ready), 32'd1);
      check("ctrl reads zero", bus.read_data, 32'd0);
      @(posedge clk); #1 bus.cs = 1'b0;

      // LEN=0: done without any SPI activity
      ev_q.delete(); starts = 0;
      wr(ADDR_LEN, 32'd0);
      wr(ADDR_CTRL, 32'h1);
      rd_check("len0 status", ADDR_STATUS, 32'h06);
      repeat (10) @(posedge clk);
      check("len0 no strobes", ev_q.size(), 32'd0);
      check("len0 no starts", starts, 32'd0);

      // Basic read
      seed = 8'hA0;
      begin_xfer(24'h012345, 4);
      wait_idle("basic");
      rd_check("basic status", ADDR_STATUS, 32'h02);
      rd_check("basic level", ADDR_LEVEL, 32'd4);
      check_events("basic", 24'h012345, 4);
      pop_expect("basic", 8'hA0, 4);
      rd_check("basic pop empty", ADDR_RDATA, 32'd0);
      rd_check("basic empty level", ADDR_LEVEL, 32'd0);
      rd_check("basic empty status", ADDR_STATUS, 32'h06);

      // Randomised transfers
      for (int r = 0; r < 3; r++) begin
         a    = 24'($urandom);
         len  = $urandom_range(12, 1);
         seed = 8'($urandom);
         begin_xfer(a, len);
         wait_idle($sformatf("rnd%0d", r));
         rd_check($sformatf("rnd%0d level", r), ADDR_LEVEL, len);
         check_events($sformatf("rnd%0d", r), a, len);
         pop_expect($sformatf("rnd%0d", r), seed, len);
      end

      // Backpressure: 20 bytes into a 16-entry FIFO
      a    = 24'($urandom);
      seed = 8'($urandom);
      begin_xfer(a, 20);
      d = 32'd0;
      for (i = 0; i < 3000 && d != DEPTH; i++) rd(ADDR_LEVEL, d);
      check("bp reached full", d, DEPTH);
      s0 = starts;
      repeat (40) @(posedge clk);
      check("bp no start while full", starts, s0);
      check("bp start count", starts, 32'd20);
      rd_check("bp status stalled", ADDR_STATUS, 32'h09);
      pop_expect("bp head", seed, 4);
      wait_idle("bp");
      rd_check("bp level end", ADDR_LEVEL, 32'd16);
      pop_expect("bp tail", 8'(seed + 8'd4), 16);
      check_events("bp", a, 20);

      // Abort during data byte 2 of LEN=10
      a    = 24'($urandom);
      seed = 8'($urandom);
      begin_xfer(a, 10);
      wait_starts(7, "abort");
      wr(ADDR_CTRL, 32'h2);
      wait_idle("abort");
      rd_check("abort status", ADDR_STATUS, 32'h12);
      rd_check("abort level", ADDR_LEVEL, 32'd3);
      check_events("abort", a, 3);
      pop_expect("abort", seed, 3);

      // Start and abort together in IDLE: only aborted is set
      ev_q.delete(); starts = 0;
      wr(ADDR_LEN, 32'd5);
      wr(ADDR_CTRL, 32'h3);
      repeat (10) @(posedge clk);
      check("start+abort no activity", ev_q.size(), 32'd0);
      rd_check("start+abort status", ADDR_STATUS, 32'h16);

      // Writes while busy are ignored
      a    = 24'($urandom);
      seed = 8'($urandom);
      begin_xfer(a, 6);
      wait_starts(2, "busy");
      wr(ADDR_LEN, 32'd99);
      wr(ADDR_FLASH, 32'h00FF_FFFF);
      wr(ADDR_CTRL, 32'h1);
      wait_idle("busy");
      repeat (10) @(posedge clk);
      rd_check("busy len kept", ADDR_LEN, 32'd6);
      rd_check("busy addr kept", ADDR_FLASH, {8'd0, a});
      rd_check("busy status", ADDR_STATUS, 32'h02);
      check_events("busy", a, 6);
      pop_expect("busy", seed, 6);

      // Asynchronous reset in the middle of a transfer
      begin_xfer(24'($urandom), 8);
      wait_starts(2, "midrst");
      @(negedge clk); #2 reset_n = 1'b0;
      #1 check("midrst strobes", {20'd0, bus.spi_enable, bus.spi_enable_vld, bus.spi_tx_data_vld,
                                  bus.spi_start, bus.spi_tx_data}, 32'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      rd_check("midrst status", ADDR_STATUS, 32'h04);
      rd_check("midrst level", ADDR_LEVEL, 32'd0);
      rd_check("midrst len", ADDR_LEN, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
